// File: rtl/simon_pkg.sv
// Shared constants for the Simon front panel: button count, indices and the
// sample-period defaults, plus a width helper for parameter-sized counters.
package simon_pkg;

  localparam int N_BUTTONS        = 4;
  localparam int SAMPLE_DIV_1MS   = 100000;
  localparam int SAMPLE_DIV_BOARD = 1000000;

  typedef enum logic [1:0] {
    BTN_RED    = 2'd0,
    BTN_GREEN  = 2'd1,
    BTN_BLUE   = 2'd2,
    BTN_YELLOW = 2'd3
  } btn_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int v;
    int w;
    v = n - 32'sd1;
    w = 32'sd1;
    while (v > 32'sd1) begin
      v = v >>> 1;
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, N-sample agreement filter,
// press/release edge pulses and a once-per-hold long-press detector.
module debounce_channel
  import simon_pkg::*;
#(
  parameter int STABLE_SAMPLES = 2,
  parameter int LONG_SAMPLES   = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_button,
  output logic o_held,
  output logic o_pressed,
  output logic o_released,
  output logic o_long_press
);

  localparam int AGREE_W = clog2w(STABLE_SAMPLES);
  localparam int HOLD_W  = clog2w(LONG_SAMPLES + 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_held;
  logic               r_pressed;
  logic               r_released;
  logic               r_long;
  logic [AGREE_W-1:0] r_agree;
  logic [HOLD_W-1:0]  r_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // A level change must be seen on STABLE_SAMPLES consecutive ticks; any
  // sample matching the current level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held     <= 1'b0;
      r_agree    <= AGREE_W'(0);
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      if (i_tick) begin
        if (r_sync2 == r_held) begin
          r_agree <= AGREE_W'(0);
        end else if (r_agree == AGREE_W'(STABLE_SAMPLES - 1)) begin
          r_held     <= ~r_held;
          r_agree    <= AGREE_W'(0);
          r_pressed  <= ~r_held;
          r_released <= r_held;
        end else begin
          r_agree <= r_agree + AGREE_W'(1);
        end
      end
    end
  end

  // Hold counter saturates, so the long-press pulse fires only once per hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= HOLD_W'(0);
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_held) begin
        r_hold <= HOLD_W'(0);
      end else if (i_tick && (r_hold != HOLD_W'(LONG_SAMPLES))) begin
        r_hold <= r_hold + HOLD_W'(1);
        r_long <= (r_hold == HOLD_W'(LONG_SAMPLES - 1));
      end
    end
  end

  assign o_held       = r_held;
  assign o_pressed    = r_pressed;
  assign o_released   = r_released;
  assign o_long_press = r_long;

endmodule

// File: rtl/debounce_array.sv
// N-channel button conditioner: one shared sample prescaler feeding per-channel
// debouncers, plus a lowest-index-wins encoder over the press pulses.
module debounce_array
  import simon_pkg::*;
#(
  parameter int N_CH           = N_BUTTONS,
  parameter int SAMPLE_DIV     = SAMPLE_DIV_BOARD,
  parameter int STABLE_SAMPLES = 2,
  parameter int LONG_SAMPLES   = 100,
  parameter int IDX_W          = clog2w(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  button,
  output logic [N_CH-1:0]  held,
  output logic [N_CH-1:0]  pressed,
  output logic [N_CH-1:0]  released,
  output logic [N_CH-1:0]  long_press,
  output logic             any_pressed,
  output logic [IDX_W-1:0] pressed_idx,
  output logic             multi_press
);

  localparam int DIV_W = clog2w(SAMPLE_DIV);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [N_CH-1:0]  w_pressed;
  logic [IDX_W-1:0] w_idx;
  logic [4:0]       w_cnt;

  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= DIV_W'(0);
    end else if (w_tick) begin
      r_div <= DIV_W'(0);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .LONG_SAMPLES  (LONG_SAMPLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_tick      (w_tick),
      .i_button    (button[g]),
      .o_held      (held[g]),
      .o_pressed   (w_pressed[g]),
      .o_released  (released[g]),
      .o_long_press(long_press[g])
    );
  end

  // Scanning from the top down leaves the lowest set index in w_idx.
  always_comb begin
    w_idx = IDX_W'(0);
    w_cnt = 5'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      w_idx = w_pressed[i] ? IDX_W'(i) : w_idx;
      w_cnt = w_cnt + {4'd0, w_pressed[i]};
    end
  end

  assign pressed     = w_pressed;
  assign any_pressed = |w_pressed;
  assign pressed_idx = w_idx;
  assign multi_press = (w_cnt >= 5'd2);

endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array: directed scenarios plus random
// button traffic, all compared against a tick-level behavioural model.
module tb_debounce_array;

  localparam int DIV = 4;
  localparam int STB = 3;
  localparam int LNG = 5;

  logic       clk;
  logic       reset;
  logic [3:0] button;
  logic [3:0] held, pressed, released, long_press;
  logic       any_pressed, multi_press;
  logic [1:0] pressed_idx;
  logic [19:0] obs;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [3:0] m_s1, m_s2, m_held, m_pressed, m_released, m_long;
  int m_ph;
  int m_run[4];
  int m_hold[4];

  debounce_array #(
    .N_CH(4), .SAMPLE_DIV(DIV), .STABLE_SAMPLES(STB), .LONG_SAMPLES(LNG), .IDX_W(2)
  ) dut (
    .clk(clk), .reset(reset), .button(button),
    .held(held), .pressed(pressed), .released(released), .long_press(long_press),
    .any_pressed(any_pressed), .pressed_idx(pressed_idx), .multi_press(multi_press)
  );

  assign obs = {held, pressed, released, long_press, any_pressed, pressed_idx, multi_press};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] exp_vec();
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_pressed[i]) idx = 2'(i);
    return {m_held, m_pressed, m_released, m_long, |m_pressed, idx,
            ($countones(m_pressed) >= 2)};
  endfunction

  // Drive one cycle, then advance the model by that edge.  The model works in
  // sample ticks: a run of disagreeing samples of length STB flips the level,
  // and a level that stays high for LNG ticks raises one long-press.
  task automatic step(input logic rst, input logic [3:0] b);
    logic tk;
    logic old;
    reset  = rst;
    button = b;
    @(posedge clk);
    m_pressed = 4'b0; m_released = 4'b0; m_long = 4'b0;
    if (rst) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_held = 4'b0; m_ph = 0;
      for (int c = 0; c < 4; c++) begin m_run[c] = 0; m_hold[c] = 0; end
    end else begin
      tk = ((m_ph % DIV) == DIV - 1);
      m_ph++;
      for (int c = 0; c < 4; c++) begin
        old = m_held[c];
        if (tk) begin
          if (m_s2[c] == m_held[c]) m_run[c] = 0;
          else begin
            m_run[c]++;
            if (m_run[c] == STB) begin
              m_held[c] = ~m_held[c];
              m_run[c] = 0;
              if (m_held[c]) m_pressed[c] = 1'b1;
              else m_released[c] = 1'b1;
            end
          end
        end
        if (!old) m_hold[c] = 0;
        else if (tk && m_hold[c] < LNG) begin
          m_hold[c]++;
          if (m_hold[c] == LNG) m_long[c] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0);
    total++;
    if (obs !== 20'h0) begin bad++; $display("FAIL reset_state got=%h exp=%h", obs, 20'h0); end
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 4'b0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    total++;
    if (obs !== 20'h0) begin bad++; $display("FAIL idle_zero got=%h exp=%h", obs, 20'h0); end
  endtask

  task automatic test_clean_press();
    int found;
    int ph;
    found = -1;
    ph = $urandom_range(0, 3);
    for (int i = 0; i < ph; i++) step(1'b0, 4'b0);
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, 4'b0100);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL clean_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (found < 0 && held[2]) begin
        found = i;
        total++;
        if (pressed !== 4'b0100 || pressed_idx !== 2'd2 || any_pressed !== 1'b1 || multi_press !== 1'b0) begin
          bad++;
          $display("FAIL clean_encode got pr=%b idx=%0d any=%b multi=%b exp pr=0100 idx=2 any=1 multi=0",
                   pressed, pressed_idx, any_pressed, multi_press);
        end
      end
    end
    total++;
    if (found < 11 || found > 14) begin bad++; $display("FAIL clean_latency got=%0d exp=11..14", found); end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'b0);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL clean_release cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_bounce();
    int pb, ps;
    logic v;
    pb = 0; ps = 0;
    for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b0, 4'b0);
    for (int i = 0; i < 40; i++) begin
      v = ((i / 3) % 2 == 0);
      step(1'b0, {2'b00, v, 1'b0});
      if (pressed[1]) pb++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL bounce_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 4'b0010);
      if (pressed[1]) ps++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL stable_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    total++;
    if (pb !== 0) begin bad++; $display("FAIL bounce_pulses got=%0d exp=0", pb); end
    total++;
    if (ps !== 1) begin bad++; $display("FAIL stable_pulses got=%0d exp=1", ps); end
    for (int i = 0; i < 30; i++) step(1'b0, 4'b0);
  endtask

  task automatic test_long_press();
    int rise, lcount, lat, rcount;
    for (int rep = 0; rep < 2; rep++) begin
      rise = -1; lcount = 0; lat = -1; rcount = 0;
      for (int i = 1; i <= 40; i++) begin
        step(1'b0, 4'b0001);
        if (held[0] && rise < 0) rise = i;
        if (long_press[0]) begin lcount++; lat = i - rise; end
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL long_model rep=%0d cyc=%0d got=%h exp=%h", rep, i, obs, exp_vec()); end
      end
      total++;
      if (lcount !== 1 || lat !== LNG * DIV) begin
        bad++;
        $display("FAIL long_once rep=%0d got count=%0d delay=%0d exp count=1 delay=%0d", rep, lcount, lat, LNG * DIV);
      end
      for (int i = 0; i < 30; i++) begin
        step(1'b0, 4'b0);
        if (released[0]) rcount++;
        if (long_press[0]) lcount++;
      end
      total++;
      if (rcount !== 1 || lcount !== 1) begin
        bad++;
        $display("FAIL long_release rep=%0d got rel=%0d long=%0d exp rel=1 long=1", rep, rcount, lcount);
      end
    end
  endtask

  task automatic test_simultaneous();
    int seen;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      step(1'b0, 4'b1010);
      if (pressed !== 4'b0) begin
        seen = 1;
        total++;
        if (pressed !== 4'b1010 || pressed_idx !== 2'd1 || multi_press !== 1'b1 || any_pressed !== 1'b1) begin
          bad++;
          $display("FAIL simul_encode got pr=%b idx=%0d multi=%b any=%b exp pr=1010 idx=1 multi=1 any=1",
                   pressed, pressed_idx, multi_press, any_pressed);
        end
      end
    end
    total++;
    if (seen !== 1) begin bad++; $display("FAIL simul_timeout got=%0d exp=1", seen); end
    for (int i = 0; i < 40; i++) step(1'b0, 4'b0);
  endtask

  task automatic test_reset_mid();
    int r0, r2, rel;
    r0 = -1; r2 = -1; rel = 0;
    for (int i = 0; i < 30; i++) step(1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0101);
    step(1'b1, 4'b0101);
    total++;
    if (obs !== 20'h0) begin bad++; $display("FAIL reset_mid_clear got=%h exp=%h", obs, 20'h0); end
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 4'b0101);
      if (held[0] && r0 < 0) r0 = i;
      if (held[2] && r2 < 0) r2 = i;
      if (released !== 4'b0) rel++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL reset_mid_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    total++;
    if (r0 !== STB * DIV || r2 !== STB * DIV || rel !== 0) begin
      bad++;
      $display("FAIL reset_mid_relatch got r0=%0d r2=%0d rel=%0d exp r0=%0d r2=%0d rel=0", r0, r2, rel, STB * DIV, STB * DIV);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 4'b0);
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic rst;
    b = 4'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) b[$urandom_range(0, 3)] = ~b[$urandom_range(0, 3)];
      rst = ($urandom_range(0, 399) == 0);
      step(rst, b);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    reset  = 1'b1;
    button = 4'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
